uc_operacao_memoria: RTL

- Multicycle control unit that sequences the operand-select/add-sub datapath, i.e. the ALU path that computes register-register results and memory effective addresses.
- Accepts one decoded operation per handshake and drives operand select (OP_MEM_I) and ADD_SUB.
- Runs the memory request handshake for loads and stores, pulses register write-back, and reports completion or timeout.
- Sits between the instruction decoder and the datapath/register file/data memory.

---
 rtl/uc_operacao_memoria.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uc_operacao_memoria.sv
`default_nettype none
// ============================================================================
// Module      : uc_operacao_memoria
// Description : Multicycle control unit for the operand-select / add-sub
//               datapath. Accepts one decoded operation per handshake,
//               drives operand select and ADD_SUB, runs the data-memory
//               request handshake for LDUR/STUR with a timeout abort,
//               strobes register write-back and counts retired operations.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_operacao_memoria #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic             mem_ack,
  output logic [1:0]       OP_MEM_I,
  output logic             ADD_SUB,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             done,
  output logic             erro,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_EXEC = 3'd1;
  localparam logic [2:0] c_MEM  = 3'd2;
  localparam logic [2:0] c_WB   = 3'd3;
  localparam logic [2:0] c_FIM  = 3'd4;

  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_SUB  = 3'b001;
  localparam logic [2:0] c_OP_LDUR = 3'b010;
  localparam logic [2:0] c_OP_STUR = 3'b011;
  localparam logic [2:0] c_OP_ADDI = 3'b100;
  localparam logic [2:0] c_OP_SUBI = 3'b101;
  localparam logic [2:0] c_OP_NOP  = 3'b110;

  // Wait counter only has to reach TIMEOUT-1.
  localparam int                  c_WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [2:0]          r_op;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_erro;
  logic [CNT_W-1:0]    r_retired;

  logic [1:0]          w_sel;
  logic                w_add_sub;
  logic                w_is_mem;
  logic                w_timeout;

  // Operand select / add-sub decoded from the latched operation only.
  always_comb begin
    w_sel     = 2'b11;
    w_add_sub = 1'b0;
    case (r_op)
      c_OP_ADD:  begin w_sel = 2'b00; w_add_sub = 1'b0; end
      c_OP_SUB:  begin w_sel = 2'b00; w_add_sub = 1'b1; end
      c_OP_LDUR: begin w_sel = 2'b01; w_add_sub = 1'b0; end
      c_OP_STUR: begin w_sel = 2'b10; w_add_sub = 1'b0; end
      c_OP_ADDI: begin w_sel = 2'b10; w_add_sub = 1'b0; end
      c_OP_SUBI: begin w_sel = 2'b10; w_add_sub = 1'b1; end
      default:   begin w_sel = 2'b11; w_add_sub = 1'b0; end
    endcase
  end

  assign w_is_mem  = (r_op == c_OP_LDUR) || (r_op == c_OP_STUR);
  // An ack on the last allowed cycle still completes the access.
  assign w_timeout = (r_state == c_MEM) && !mem_ack && (r_wait == c_WAIT_LAST);

  // Next-state sequencing of the multicycle operation.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (op_valid) w_next_state = c_EXEC;
      c_EXEC: begin
        if (w_is_mem)                  w_next_state = c_MEM;
        else if (r_op[2:1] == 2'b11)   w_next_state = c_FIM;
        else                           w_next_state = c_WB;
      end
      c_MEM: begin
        if (mem_ack)        w_next_state = (r_op == c_OP_LDUR) ? c_WB : c_FIM;
        else if (w_timeout) w_next_state = c_IDLE;
      end
      c_WB:    w_next_state = c_FIM;
      c_FIM:   w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // State, latched op, memory wait counter, abort flag and retired counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_op      <= c_OP_NOP;
      r_wait    <= '0;
      r_erro    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      r_erro  <= w_timeout;
      if ((r_state == c_IDLE) && op_valid) r_op <= op;
      if (r_state == c_MEM) r_wait <= r_wait + 1'b1;
      else                  r_wait <= '0;
      if (r_state == c_FIM) r_retired <= r_retired + 1'b1;
    end
  end

  // Outputs decoded from state and latched op only.
  assign op_ready  = (r_state == c_IDLE);
  assign OP_MEM_I  = (r_state == c_IDLE) ? 2'b11 : w_sel;
  assign ADD_SUB   = (r_state == c_IDLE) ? 1'b0  : w_add_sub;
  assign mem_read  = (r_state == c_MEM) && (r_op == c_OP_LDUR);
  assign mem_write = (r_state == c_MEM) && (r_op == c_OP_STUR);
  assign reg_write = (r_state == c_WB);
  assign done      = (r_state == c_FIM);
  assign erro      = r_erro;
  assign retired   = r_retired;

endmodule
`default_nettype wire
